// File: rtl/rv_mc_sequencer.sv
// rv_mc_sequencer: loadable-microcode control sequencer for the multi-cycle RV32I datapath.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   opcode            instr[6:2], sampled only when leaving DECODE
//   bcond             ALU branch condition, sampled only in BRANCH_S
//   mem_ready         memory access completes this cycle (stalls FETCH/STORE_MEM/LOAD2)
//   uc_we/uc_addr/uc_data  microcode store write port (accepted in any state, even in reset)
//   ctrl              registered microword of the current state
//   state             current state code
//   trap              sticky illegal-opcode flag, cleared by rst
//   retire            one-cycle pulse when FETCH is re-entered from another state
//   instret           retired-instruction counter, wraps modulo 2^CNT_W
module rv_mc_sequencer #(
  parameter int unsigned UW    = 13,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       opcode,
  input  logic             bcond,
  input  logic             mem_ready,
  input  logic             uc_we,
  input  logic [4:0]       uc_addr,
  input  logic [UW-1:0]    uc_data,
  output logic [UW-1:0]    ctrl,
  output logic [4:0]       state,
  output logic             trap,
  output logic             retire,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [4:0] {
    StFetch     = 5'd0,
    StDecode    = 5'd1,
    StBranch    = 5'd2,
    StBcond1    = 5'd3,
    StJalr      = 5'd4,
    StJalr2     = 5'd5,
    StJal       = 5'd6,
    StJal2      = 5'd7,
    StAlu2Pc    = 5'd8,
    StAuipc     = 5'd9,
    StWriteBack = 5'd10,
    StLui       = 5'd11,
    StStore     = 5'd12,
    StStoreMem  = 5'd13,
    StLoad      = 5'd14,
    StLoad2     = 5'd15,
    StLoadWrite = 5'd16,
    StIType     = 5'd17,
    StRType     = 5'd18,
    StTrap      = 5'd19
  } state_e;

  state_e             state_q, state_d, fsm_nxt;
  logic [UW-1:0]      ctrl_q, ctrl_d;
  logic               trap_q, trap_d;
  logic               retire_q, retire_d;
  logic [CNT_W-1:0]   instret_q, instret_d;

  // Not reset: software loads the store while rst is held.
  logic [UW-1:0]      ucode_mem [32];

  always_ff @(posedge clk) begin
    if (uc_we) begin
      ucode_mem[uc_addr] <= uc_data;
    end
  end

  // Pure next-state function, reset folded in below.
  always_comb begin
    fsm_nxt = StTrap;
    unique case (state_q)
      StFetch:     fsm_nxt = mem_ready ? StDecode : StFetch;
      StDecode: begin
        case (opcode)
          5'b11000: fsm_nxt = StBranch;
          5'b11001: fsm_nxt = StJalr;
          5'b11011: fsm_nxt = StJal;
          5'b00101: fsm_nxt = StAuipc;
          5'b01101: fsm_nxt = StLui;
          5'b01000: fsm_nxt = StStore;
          5'b00000: fsm_nxt = StLoad;
          5'b00100: fsm_nxt = StIType;
          5'b01100: fsm_nxt = StRType;
          default:  fsm_nxt = StTrap;
        endcase
      end
      StBranch:    fsm_nxt = bcond ? StBcond1 : StFetch;
      StBcond1:    fsm_nxt = StAlu2Pc;
      StJalr:      fsm_nxt = StJalr2;
      StJalr2:     fsm_nxt = StAlu2Pc;
      StJal:       fsm_nxt = StJal2;
      StJal2:      fsm_nxt = StAlu2Pc;
      StAlu2Pc:    fsm_nxt = StFetch;
      StAuipc:     fsm_nxt = StWriteBack;
      StLui:       fsm_nxt = StWriteBack;
      StIType:     fsm_nxt = StWriteBack;
      StRType:     fsm_nxt = StWriteBack;
      StWriteBack: fsm_nxt = StFetch;
      StStore:     fsm_nxt = StStoreMem;
      StStoreMem:  fsm_nxt = mem_ready ? StFetch : StStoreMem;
      StLoad:      fsm_nxt = StLoad2;
      StLoad2:     fsm_nxt = mem_ready ? StLoadWrite : StLoad2;
      StLoadWrite: fsm_nxt = StFetch;
      default:     fsm_nxt = StTrap;  // TRAP and unused codes 20-31
    endcase
  end

  always_comb begin
    state_d   = rst ? StFetch : fsm_nxt;
    // Read of the store sees the pre-write word when a write hits the same address.
    ctrl_d    = ucode_mem[state_d];
    retire_d  = !rst && (state_d == StFetch) && (state_q != StFetch);
    instret_d = rst ? '0 : instret_q + CNT_W'(retire_d);
    trap_d    = !rst && (trap_q || (state_d == StTrap));
  end

  always_ff @(posedge clk) begin
    state_q   <= state_d;
    ctrl_q    <= ctrl_d;
    retire_q  <= retire_d;
    instret_q <= instret_d;
    trap_q    <= trap_d;
  end

  assign state   = state_q;
  assign ctrl    = ctrl_q;
  assign trap    = trap_q;
  assign retire  = retire_q;
  assign instret = instret_q;

endmodule
